// File: rtl/dmem_responder_if.sv
// Data-memory port between the core (master) and a responder (slave).
// One request at a time on a req/gnt handshake. The response is reported on
// a single-cycle rvalid together with rdata and err.
//   req    master->slave  request valid
//   gnt    slave->master  request accepted this cycle
//   we     master->slave  1 = write, 0 = read
//   be     master->slave  byte enables, be[n] selects wdata[8n+7:8n]
//   addr   master->slave  byte address, bits [1:0] ignored
//   wdata  master->slave  write data
//   rvalid slave->master  response valid, one-cycle pulse
//   rdata  slave->master  read data, qualified by rvalid
//   err    slave->master  decode/access error, qualified by rvalid
interface dmem_responder_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory port. It serves a word-addressed
// SRAM, a byte-writable display register and a read-only seconds counter.
// It also generates the one-second tick pulse used by the core.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   bus             dmem_responder_if slave modport (req/gnt/rvalid handshake)
//   data_display_o  display register contents
//   flag1s_o        one-cycle pulse every TICK_CYCLES clocks
//
// state | meaning
// IDLE  | ready; gnt follows req, accept commits writes immediately
// WAIT  | wait-state countdown between accept and response
// RESP  | rvalid/rdata/err presented for exactly one cycle
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter logic [31:0] DISP_ADDR   = 32'h1000_0000,
  parameter logic [31:0] TICK_ADDR   = 32'h1000_0004
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dmem_responder_if.slave        bus,
  output logic [31:0]            data_display_o,
  output logic                   flag1s_o
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [31:0] TC_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [31:0] TC_PRE  = 32'(TICK_CYCLES - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {TGT_SRAM, TGT_DISP, TGT_TICK, TGT_NONE} tgt_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        gnt;
  logic        accept;

  logic [29:0] word_q;
  logic        we_q;
  logic [29:0] cur_word;
  logic        cur_we;
  tgt_t        cur_tgt;
  logic [31:0] rd_value;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] presc_q;
  logic [31:0] sec_q;

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr[1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt = bus.req;
        if (bus.req) begin
          if (WS == 4'd0) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept     = (state_q == ST_IDLE) && bus.req;
  assign bus.gnt    = gnt;
  assign bus.rvalid = (state_q == ST_RESP);
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

  // ------------------------------------------------------ request latch
  // Only the word address and direction outlive the accept edge: write data
  // is committed at accept, so be/wdata never need to be held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      we_q   <= 1'b0;
    end else if (accept) begin
      word_q <= bus.addr[31:2];
      we_q   <= bus.we;
    end
  end

  // With zero wait states the response is sampled on the accept edge, so the
  // decode must look at the live bus while idle and the latched copy after.
  assign cur_word = (state_q == ST_IDLE) ? bus.addr[31:2] : word_q;
  assign cur_we   = (state_q == ST_IDLE) ? bus.we         : we_q;

  always_comb begin
    cur_tgt = TGT_NONE;
    if ({2'b00, cur_word} < 32'(DEPTH)) begin
      cur_tgt = TGT_SRAM;
    end else if (cur_word == DISP_ADDR[31:2]) begin
      cur_tgt = TGT_DISP;
    end else if (cur_word == TICK_ADDR[31:2] && !cur_we) begin
      cur_tgt = TGT_TICK;
    end
  end

  always_comb begin
    rd_value = '0;
    unique case (cur_tgt)
      TGT_SRAM: rd_value = mem[cur_word[AW-1:0]];
      TGT_DISP: rd_value = data_display_o;
      TGT_TICK: rd_value = sec_q;
      default:  rd_value = '0;
    endcase
  end

  // ------------------------------------------------------------- writes
  always_ff @(posedge clk_i) begin
    if (accept && bus.we && cur_tgt == TGT_SRAM) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be[b]) begin
          mem[cur_word[AW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_display_o <= '0;
    end else if (accept && bus.we && cur_tgt == TGT_DISP) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be[b]) begin
          data_display_o[8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------- response
  // Read data is captured on the edge entering RESP and cleared on every
  // other edge, so rdata is zero whenever rvalid is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_d == ST_RESP) begin
      err_q   <= (cur_tgt == TGT_NONE);
      rdata_q <= (cur_we || cur_tgt == TGT_NONE) ? 32'd0 : rd_value;
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // --------------------------------------------------------------- tick
  // flag1s_o is registered one count early so it is high exactly while the
  // prescaler sits at its last value; the seconds counter steps on that
  // same edge, so a coincident read sees the pre-increment value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q  <= '0;
      flag1s_o <= 1'b0;
      sec_q    <= '0;
    end else begin
      presc_q  <= (presc_q == TC_LAST) ? 32'd0 : presc_q + 32'd1;
      flag1s_o <= (presc_q == TC_PRE);
      if (flag1s_o) begin
        sec_q <= sec_q + 32'd1;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port. Accepts one request at a time on a req/gnt/rvalid handshake.
- Serves a word-addressed SRAM array plus two memory-mapped registers: the display register driving data_display_o, and a read-only seconds counter.
- Generates the 1-second tick pulse flag1s_o consumed by the core.
- Sits beside the core in the SoC top, replacing the always-granted data SRAM.

Parameters:
DEPTH, 1024, SRAM size in 32-bit words; valid byte addresses 0 .. 4*DEPTH-1
WAIT_STATES, 1, extra cycles between accept and response (0..15)
TICK_CYCLES, 50000000, clk_i cycles per flag1s_o pulse (>=2)
DISP_ADDR, 32'h1000_0000, byte address of display register (R/W)
TICK_ADDR, 32'h1000_0004, byte address of seconds counter (read-only)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
req_i  input  1  request valid
gnt_o  output 1  request accepted this cycle
we_i  input  1  1 = write, 0 = read
be_i  input  4  byte enables, be_i[n] -> wdata_i[8n+7:8n]
addr_i  input  32  byte address; addr_i[1:0] ignored
wdata_i  input  32  write data
rvalid_o  output 1  response valid, one-cycle pulse
rdata_o  output 32  read data, valid with rvalid_o
err_o  output 1  decode/access error, valid with rvalid_o
data_display_o  output 32  display register contents
flag1s_o  output 1  one-cycle pulse every TICK_CYCLES cycles

Behaviour:
- Reset (asynchronous on rst_i high): FSM to IDLE. gnt_o, rvalid_o, err_o, flag1s_o = 0. rdata_o, data_display_o, prescaler and seconds counter = 0. SRAM contents not reset.
- Reset mid-transaction: transaction dropped, no rvalid_o. A write already committed at accept stays in memory.
- FSM states IDLE, WAIT, RESP.
  - IDLE: gnt_o = req_i (combinational); all other states gnt_o = 0. On a clock edge with req_i & gnt_o, latch we/be/addr/wdata and decode. Next state is RESP if WAIT_STATES = 0, else WAIT with counter = WAIT_STATES.
  - WAIT: decrement the counter; go to RESP when it reaches 1 at the edge.
  - RESP: rvalid_o = 1 for exactly one cycle, then IDLE.
- Latency: rvalid_o is high in cycle N+WAIT_STATES+1, where N is the accept cycle. Throughput is one transaction per WAIT_STATES+2 cycles. No request is accepted in RESP.
- req_i/addr_i changes after accept are ignored; the transaction is committed.
- Writes take effect at the accept edge; only bytes with be_i set are updated. be_i = 0000 is a successful no-op. A read issued right after a write to the same address returns the new data.
- Reads sample the target at the RESP transition. rdata_o = full 32-bit word regardless of be_i. rdata_o = 0 whenever rvalid_o = 0.
- Decode on addr_i[31:2]:
  - SRAM when addr < 4*DEPTH.
  - DISP_ADDR: readable; writes byte-masked into data_display_o, visible the cycle after the accept edge.
  - TICK_ADDR: read returns the seconds counter value at response; a write is an error.
  - Any other address, or a write to TICK_ADDR: err_o = 1 with rvalid_o, rdata_o = 0, no state change.
- Tick: prescaler counts 0..TICK_CYCLES-1 and wraps. flag1s_o is a registered pulse, high for one cycle per wrap. The seconds counter increments on each pulse; 32-bit, wraps FFFF_FFFF -> 0.
- The tick logic runs independently of the bus FSM. A TICK_ADDR read coinciding with an increment returns the pre-increment value.

Test Plan:
- Reset, WAIT_STATES=1: hold rst_i 3 cycles, release -> all outputs 0. req_i=1 in cycle 0 -> gnt_o=1 in cycle 0, rvalid_o in cycle 2 only.
- Write addr 0x10 wdata 0xA5A5_1234 be 1111; write addr 0x10 wdata 0xFFFF_FFFF be 0010; read addr 0x10 -> rdata_o=0xA5A5_FF34, err_o=0.
- Write DISP_ADDR 0x0000_00C3 be 0001 -> data_display_o=0x0000_00C3 the cycle after accept; read DISP_ADDR -> 0x0000_00C3.
- TICK_CYCLES=10: run 35 cycles after reset -> flag1s_o pulses at cycles 9, 19, 29. Read TICK_ADDR afterwards -> 3. Write TICK_ADDR -> err_o=1, rdata_o=0, counter unchanged.
- Read 4*DEPTH (0x1000), and write 0x2000_0000 -> each returns rvalid_o=1, err_o=1, rdata_o=0; SRAM and display unchanged.
- Assert rst_i during WAIT after a read accept -> no rvalid_o. Post-reset req_i with WAIT_STATES=0 -> rvalid_o exactly 1 cycle after accept.
